// File: rtl/seq_uart_cmd_pkg.sv
`default_nettype none
// seq_uart_cmd_pkg -- shared constants, parser state encoding and helpers.
// Rev 1.0
package seq_uart_cmd_pkg;

  localparam logic [7:0] CMD_SYNC = 8'hA5;
  localparam int         CNT_W    = 8;

  typedef enum logic [1:0] {
    S_SYNC = 2'd0,
    S_INST = 2'd1,
    S_CHK  = 2'd2
  } parse_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_cmd_fifo.sv
`default_nettype none
// seq_cmd_fifo -- synchronous FIFO with registered count/full/empty; push is
// accepted while full when a pop happens in the same cycle. Rev 1.0
module seq_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/seq_uart_cmd.sv
`default_nettype none
// seq_uart_cmd -- validates A5/INST/~INST frames from the UART receiver, buffers
// them and issues them to the sequencer as paced one-cycle strobes. Rev 1.0
module seq_uart_cmd
  import seq_uart_cmd_pkg::*;
#(
  parameter int INST_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYC     = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic              i_seq_busy,
  output logic [INST_W-1:0] o_inst,
  output logic              o_inst_valid,
  output logic              o_fifo_full,
  output logic [CNT_W-1:0]  o_err_cnt,
  output logic [CNT_W-1:0]  o_drop_cnt
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC);

  parse_state_t      state;
  logic [7:0]        inst_byte;
  logic [TMR_W-1:0]  timer;
  logic [GAP_W-1:0]  gap;
  logic              timed_out;
  logic              chk_match;
  logic              issue;
  logic              fifo_empty;
  logic [INST_W-1:0] fifo_head;

  assign timed_out = (state != S_SYNC) && !i_rx_valid && (timer == TMR_LAST);
  assign chk_match = (state == S_CHK) && i_rx_valid && (i_rx_data == ~inst_byte);
  assign issue     = !fifo_empty && (gap == '0) && !i_seq_busy;

  seq_cmd_fifo #(
    .WIDTH (INST_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (chk_match),
    .push_data (INST_W'(inst_byte)),
    .pop       (issue),
    .pop_data  (fifo_head),
    .full      (o_fifo_full),
    .empty     (fifo_empty)
  );

  // Mid-frame bytes are always data; only S_SYNC looks for the sync value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_SYNC;
      inst_byte  <= '0;
      timer      <= '0;
      o_err_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (i_rx_valid || (state == S_SYNC) || timed_out) timer <= '0;
      else                                               timer <= timer + 1'b1;

      case (state)
        S_SYNC: begin
          if (i_rx_valid && (i_rx_data == CMD_SYNC)) state <= S_INST;
        end
        S_INST: begin
          if (i_rx_valid) begin
            inst_byte <= i_rx_data;
            state     <= S_CHK;
          end
        end
        S_CHK: begin
          if (i_rx_valid) begin
            state <= S_SYNC;
            if (!chk_match)                  o_err_cnt  <= sat_inc(o_err_cnt);
            else if (o_fifo_full && !issue)  o_drop_cnt <= sat_inc(o_drop_cnt);
          end
        end
        default: state <= S_SYNC;
      endcase

      if (timed_out) begin
        state     <= S_SYNC;
        o_err_cnt <= sat_inc(o_err_cnt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_inst       <= '0;
      o_inst_valid <= 1'b0;
      gap          <= '0;
    end else begin
      o_inst_valid <= issue;
      if (issue) begin
        o_inst <= fifo_head;
        gap    <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
